instruction_issuer: RTL and testbench

//  Producer end of the GPU instruction interface. Assembles a host byte stream (UART RX) into 32-bit

---
 rtl/gpu_defs.sv | 21 ++
 rtl/instruction_fifo.sv | 59 +++++
 rtl/instruction_issuer.sv | 122 ++++++++++++
 tb/tb_instruction_issuer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gpu_defs.sv
// Shared constants for the GPU instruction path: opcodes, visible-area limits
// and the instruction word layout.
package gpu_defs;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPCODE_W = 8;

    localparam logic [OPCODE_W-1:0] SET_BG_COLOR       = 8'h01;
    localparam logic [OPCODE_W-1:0] SET_RED_BG_COLOR   = 8'h02;
    localparam logic [OPCODE_W-1:0] SET_GREEN_BG_COLOR = 8'h03;
    localparam logic [OPCODE_W-1:0] SET_BLUE_BG_COLOR  = 8'h04;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] V_VISIBLE = 10'd480;

    typedef enum logic {
        ASM_IDLE,
        ASM_COLLECT
    } asm_state_e;

endpackage

// File: rtl/instruction_fifo.sv
// Synchronous instruction FIFO; full/empty are judged on the registered count,
// so a push into a full FIFO is dropped even if a pop happens on the same edge.
module instruction_fifo
    import gpu_defs::*;
#(
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_push,
    input  logic [INSTR_W-1:0] i_data,
    input  logic               i_pop,
    output logic [INSTR_W-1:0] o_head,
    output logic               o_full,
    output logic               o_empty
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [INSTR_W-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push;
    logic                  do_pop;

    assign o_full  = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_head  = mem_q[rd_ptr_q];
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instruction_issuer.sv
// Assembles host bytes into 32-bit instructions, buffers them and issues one
// per cycle to the pixel generator, optionally only while the beam is blanking.
module instruction_issuer
    import gpu_defs::*;
#(
    parameter int unsigned BYTE_TIMEOUT    = 50000,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2,
    parameter int unsigned SYNC_TO_BLANK   = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_byte,
    input  logic               i_byte_valid,
    input  logic [9:0]         i_pixel_x,
    input  logic [9:0]         i_pixel_y,
    output logic [INSTR_W-1:0] o_instruction,
    output logic               o_instruction_ready,
    output logic               o_fifo_full,
    output logic               o_overflow,
    output logic               o_frame_error
);

    localparam int unsigned TW = $clog2(BYTE_TIMEOUT);

    asm_state_e         state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [23:0]        word_q, word_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               fe_d;
    logic               push;
    logic               pop;
    logic               blank;
    logic               fifo_empty;
    logic [INSTR_W-1:0] fifo_head;
    logic [INSTR_W-1:0] instr_q;
    logic               ready_q;
    logic               overflow_q;
    logic               fe_q;

    // A byte on the timeout cycle wins: the byte branch is checked first.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        timer_d = timer_q;
        fe_d    = 1'b0;
        push    = 1'b0;
        if (i_byte_valid) begin
            timer_d = '0;
            if (cnt_q == 2'd3) begin
                push    = 1'b1;
                cnt_d   = '0;
                state_d = ASM_IDLE;
            end else begin
                word_d[{cnt_q, 3'b000} +: 8] = i_byte;
                cnt_d   = cnt_q + 1'b1;
                state_d = ASM_COLLECT;
            end
        end else if (state_q == ASM_COLLECT) begin
            if (timer_q == TW'(BYTE_TIMEOUT - 1)) begin
                timer_d = '0;
                cnt_d   = '0;
                fe_d    = 1'b1;
                state_d = ASM_IDLE;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ASM_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            timer_q <= timer_d;
        end
    end

    instruction_fifo #(
        .DEPTH_LOG2(FIFO_DEPTH_LOG2)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_data  ({i_byte, word_q}),
        .i_pop   (pop),
        .o_head  (fifo_head),
        .o_full  (o_fifo_full),
        .o_empty (fifo_empty)
    );

    assign blank = (i_pixel_x >= H_VISIBLE) || (i_pixel_y >= V_VISIBLE);
    assign pop   = !fifo_empty && (blank || (SYNC_TO_BLANK == 0));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            instr_q    <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            ready_q    <= pop;
            overflow_q <= overflow_q | (push && o_fifo_full);
            fe_q       <= fe_d;
            if (pop) begin
                instr_q <= fifo_head;
            end
        end
    end

    assign o_instruction       = instr_q;
    assign o_instruction_ready = ready_q;
    assign o_overflow          = overflow_q;
    assign o_frame_error       = fe_q;

endmodule

// File: tb/tb_instruction_issuer.sv
// Scoreboard bench: expected words are queued at stimulus time and a monitor
// pops/compares them whenever an instruction-ready strobe appears.
module tb_instruction_issuer;

    localparam int unsigned TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  b, b0;
    logic        v, v0;
    logic [9:0]  x, y, x0, y0;
    logic [31:0] instr, instr0;
    logic        rdy, full, ovf, fe;
    logic        rdy0, full0, ovf0, fe0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp0_q[$];
    int          iss[$];
    int          iss0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instruction_issuer #(
        .BYTE_TIMEOUT(TO),
        .FIFO_DEPTH_LOG2(2),
        .SYNC_TO_BLANK(1)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_byte(b), .i_byte_valid(v),
        .i_pixel_x(x), .i_pixel_y(y),
        .o_instruction(instr), .o_instruction_ready(rdy), .o_fifo_full(full),
        .o_overflow(ovf), .o_frame_error(fe)
    );

    instruction_issuer #(
        .BYTE_TIMEOUT(50000),
        .FIFO_DEPTH_LOG2(2),
        .SYNC_TO_BLANK(0)
    ) dut0 (
        .i_clk(clk), .i_reset(rst), .i_byte(b0), .i_byte_valid(v0),
        .i_pixel_x(x0), .i_pixel_y(y0),
        .o_instruction(instr0), .o_instruction_ready(rdy0), .o_fifo_full(full0),
        .o_overflow(ovf0), .o_frame_error(fe0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rdy) begin
                iss.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got %h expected none", instr);
                end else begin
                    chk("issue", instr, exp_q.pop_front());
                end
            end
            if (rdy0) begin
                iss0.push_back(cyc);
                if (exp0_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue0: got %h expected none", instr0);
                end else begin
                    chk("issue0", instr0, exp0_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Ends on the falling edge right after the 4th byte is sampled.
    task automatic send_word(input logic [31:0] w, input bit expect_push);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            b = w[8*k +: 8];
            v = 1'b1;
        end
        if (expect_push) exp_q.push_back(w);
        @(negedge clk);
        v = 1'b0;
    endtask

    initial begin
        int n, fe_n, fe_pos;
        logic [31:0] words [5];
        rst = 1'b1; b = '0; v = 1'b0; x = 10'd700; y = 10'd0;
        b0 = '0; v0 = 1'b0; x0 = 10'd100; y0 = 10'd100;
        tick(2);
        chk("rst_instr", instr, 32'h0);
        chk("rst_ready", {31'b0, rdy}, 32'h0);
        chk("rst_full", {31'b0, full}, 32'h0);
        chk("rst_ovf", {31'b0, ovf}, 32'h0);
        rst = 1'b0;

        // 1: latency and single-cycle strobe while blanking
        send_word(32'h000FA501, 1'b1);
        chk("t1_lat_early", {31'b0, rdy}, 32'h0);
        tick(1);
        chk("t1_ready", {31'b0, rdy}, 32'h1);
        chk("t1_instr", instr, 32'h000FA501);
        tick(1);
        chk("t1_pulse_end", {31'b0, rdy}, 32'h0);

        // 2: held while visible, released on first blanking column
        x = 10'd100; y = 10'd100;
        send_word(32'h00332211, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("t2_hold", {31'b0, rdy}, 32'h0);
        end
        x = 10'd640;
        tick(1);
        chk("t2_ready", {31'b0, rdy}, 32'h1);
        tick(1);
        chk("t2_pulse_end", {31'b0, rdy}, 32'h0);

        // 3: partial word timeout
        x = 10'd700;
        n = iss.size();
        @(negedge clk); b = 8'h01; v = 1'b1;
        @(negedge clk); b = 8'h22;
        @(negedge clk); v = 1'b0;
        fe_n = 0; fe_pos = -1;
        for (int i = 1; i <= int'(TO) + 5; i++) begin
            tick(1);
            if (fe) begin
                fe_n++;
                fe_pos = i;
            end
        end
        chk("t3_fe_count", 32'(fe_n), 32'd1);
        chk("t3_fe_cycle", 32'(fe_pos), 32'(TO));
        chk("t3_no_issue", 32'(iss.size() - n), 32'd0);
        send_word(32'h00000003, 1'b1);
        tick(3);

        // 4: fill, overflow, then drain in order at blanking
        x = 10'd100; y = 10'd100;
        words[0] = 32'h00102001; words[1] = 32'h00304002; words[2] = 32'h00506003;
        words[3] = 32'h00708004; words[4] = 32'h00DEAD01;
        for (int i = 0; i < 4; i++) send_word(words[i], 1'b1);
        chk("t4_full", {31'b0, full}, 32'h1);
        chk("t4_no_ovf_yet", {31'b0, ovf}, 32'h0);
        send_word(words[4], 1'b0);
        chk("t4_ovf", {31'b0, ovf}, 32'h1);
        chk("t4_still_full", {31'b0, full}, 32'h1);
        n = iss.size();
        x = 10'd700;
        tick(6);
        chk("t4_issue_count", 32'(iss.size() - n), 32'd4);
        if (iss.size() - n == 4) chk("t4_back_to_back", 32'(iss[n+3] - iss[n]), 32'd3);
        chk("t4_drained", {31'b0, full}, 32'h0);
        chk("t4_ovf_sticky", {31'b0, ovf}, 32'h1);

        // 5: reset mid-word discards partial bytes and sticky flags
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            b = 8'hAA + 8'(k);
            v = 1'b1;
        end
        @(negedge clk); v = 1'b0; rst = 1'b1;
        tick(1);
        chk("t5_instr", instr, 32'h0);
        chk("t5_ready", {31'b0, rdy}, 32'h0);
        chk("t5_full", {31'b0, full}, 32'h0);
        chk("t5_ovf", {31'b0, ovf}, 32'h0);
        chk("t5_fe", {31'b0, fe}, 32'h0);
        rst = 1'b0;
        n = iss.size();
        send_word(32'h00000004, 1'b1);
        tick(4);
        chk("t5_one_issue", 32'(iss.size() - n), 32'd1);

        // 6: unsynchronised issue of a back-to-back byte stream
        n = iss0.size();
        exp0_q.push_back(32'h00000002);
        exp0_q.push_back(32'h00000003);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b0 = (i == 0) ? 8'h02 : (i == 4) ? 8'h03 : 8'h00;
            v0 = 1'b1;
        end
        @(negedge clk); v0 = 1'b0;
        tick(4);
        chk("t6_issue_count", 32'(iss0.size() - n), 32'd2);
        if (iss0.size() - n == 2) chk("t6_spacing", 32'(iss0[n+1] - iss0[n]), 32'd4);
        chk("t6_no_ovf", {31'b0, ovf0}, 32'h0);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("exp0_q_empty", 32'(exp0_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
